gcd_req_master: RTL and testbench

//   Initiator side of the gcd start/done interface. Accepts operand pairs on a valid/ready stream
//   and buffers them in a small FIFO. Issues them one at a time to a gcd core (start, a, b),

---
 rtl/gcd_req_master_if.sv | 39 +++
 rtl/gcd_req_master.sv | 192 +++++++++++++++++++
 tb/tb_gcd_req_master.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_req_master_if.sv
// Handshake bundle for gcd_req_master: operand stream in, result stream out,
// and the start/done link to the gcd core.
// master: the request master itself. slave: the environment around it
// (host front-end, result consumer and gcd core).
interface gcd_req_master_if #(
    parameter int unsigned WIDTH = 32
);
    // Operand stream
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    // Result stream
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [7:0]       out_seq;
    logic             out_err;

    // Core link
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_a;
    logic [WIDTH-1:0] gcd_b;
    logic [WIDTH-1:0] gcd_result;
    logic             gcd_done;

    modport master (
        input  in_valid, in_a, in_b, out_ready, gcd_result, gcd_done,
        output in_ready, out_valid, out_result, out_seq, out_err,
        output gcd_start, gcd_a, gcd_b
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready, gcd_result, gcd_done,
        input  in_ready, out_valid, out_result, out_seq, out_err,
        input  gcd_start, gcd_a, gcd_b
    );
endinterface

// File: rtl/gcd_req_master.sv
// gcd_req_master: buffers operand pairs in a FIFO, issues them one at a time
// to a gcd core over a start/done link, and returns results in push order with
// an 8-bit sequence tag. At most one operation is outstanding.
// Optional feature: define GCD_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT
// cycles (result 0, out_err 1). The TIMEOUT parameter exists only in that build.
module gcd_req_master #(
    parameter int unsigned WIDTH   = 32,
`ifdef GCD_TIMEOUT_EN
    parameter int unsigned TIMEOUT = 1024,
`endif
    parameter int unsigned DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    gcd_req_master_if.master  bus,
    output logic              busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = 8;
`ifdef GCD_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BLANK,
        S_WAIT,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    seq_q, seq_d;
    logic             gcd_start_q, gcd_start_d;
    logic [WIDTH-1:0] gcd_a_q, gcd_a_d;
    logic [WIDTH-1:0] gcd_b_q, gcd_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [SW-1:0]    out_seq_q, out_seq_d;
    logic             err_q, err_d;
`ifdef GCD_TIMEOUT_EN
    logic [TW-1:0]    tcnt_q, tcnt_d;
`endif

    logic push;
    logic pop;
    logic full;

    // Full blocks pushes regardless of a same-cycle pop.
    assign full = (count_q == CW'(DEPTH));
    assign push = bus.in_valid && !full;

    // Output ports driven straight from state flops.
    assign bus.in_ready   = !full;
    assign bus.out_valid  = (state_q == S_RESP);
    assign bus.out_result = result_q;
    assign bus.out_seq    = out_seq_q;
    assign bus.out_err    = err_q;
    assign bus.gcd_start  = gcd_start_q;
    assign bus.gcd_a      = gcd_a_q;
    assign bus.gcd_b      = gcd_b_q;
    assign busy           = (state_q != S_IDLE) || (count_q != '0);

    // Next-state, issue and capture logic.
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        gcd_start_d = 1'b0;
        gcd_a_d     = gcd_a_q;
        gcd_b_d     = gcd_b_q;
        result_d    = result_q;
        out_seq_d   = out_seq_q;
        err_d       = err_q;
        pop         = 1'b0;
`ifdef GCD_TIMEOUT_EN
        tcnt_d      = tcnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // Operands and start pulse land together on the edge into ISSUE.
                if (count_q != '0) begin
                    pop         = 1'b1;
                    gcd_a_d     = mem_a_q[rd_ptr_q];
                    gcd_b_d     = mem_b_q[rd_ptr_q];
                    gcd_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_BLANK;
            end
            S_BLANK: begin
                // gcd_done here may still be the previous op's level.
                state_d = S_WAIT;
`ifdef GCD_TIMEOUT_EN
                tcnt_d  = '0;
`endif
            end
            S_WAIT: begin
                if (bus.gcd_done) begin
                    result_d  = bus.gcd_result;
                    out_seq_d = seq_q;
                    err_d     = 1'b0;
                    seq_d     = seq_q + SW'(1);
                    state_d   = S_RESP;
                end
`ifdef GCD_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    result_d  = '0;
                    out_seq_d = seq_q;
                    err_d     = 1'b1;
                    seq_d     = seq_q + SW'(1);
                    state_d   = S_RESP;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            S_RESP: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else if (push) begin
            mem_a_q[wr_ptr_q] <= bus.in_a;
            mem_b_q[wr_ptr_q] <= bus.in_b;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seq_q       <= '0;
            gcd_start_q <= 1'b0;
            gcd_a_q     <= '0;
            gcd_b_q     <= '0;
            result_q    <= '0;
            out_seq_q   <= '0;
            err_q       <= 1'b0;
`ifdef GCD_TIMEOUT_EN
            tcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
            gcd_start_q <= gcd_start_d;
            gcd_a_q     <= gcd_a_d;
            gcd_b_q     <= gcd_b_d;
            result_q    <= result_d;
            out_seq_q   <= out_seq_d;
            err_q       <= err_d;
`ifdef GCD_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_gcd_req_master.sv
// Bench for gcd_req_master: directed operand pairs with hand-computed gcds,
// a behavioural gcd core (done held high one cycle into the next op to mimic
// a stale level), and a scoreboard monitor that checks results in order.
module tb_gcd_req_master;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [7:0]       seq;
        logic             err;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } iss_t;

    logic clk;
    logic reset_n;
    logic busy;

    gcd_req_master_if #(.WIDTH(WIDTH)) bus ();

`ifdef GCD_TIMEOUT_EN
    gcd_req_master #(.WIDTH(WIDTH), .TIMEOUT(16), .DEPTH(DEPTH)) dut (
`else
    gcd_req_master #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
`endif
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    exp_t  sb_q[$];
    iss_t  iss_q[$];
    logic [7:0] exp_seq = 8'd0;
    int    cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural gcd core.
    logic             core_en;
    int               core_lat;
    int               core_cnt;
    logic             core_pend;
    logic             core_stale;
    logic             prev_start;
    logic [WIDTH-1:0] op_a, op_b;
    int               start_cyc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.gcd_done   <= 1'b0;
            bus.gcd_result <= '0;
            core_pend      <= 1'b0;
            core_stale     <= 1'b0;
            core_cnt       <= 0;
            prev_start     <= 1'b0;
        end else begin
            prev_start <= bus.gcd_start;
            if (bus.gcd_start) begin
                iss_t e;
                chk("start_one_cycle", WIDTH'(prev_start), WIDTH'(0));
                if (iss_q.size() == 0) begin
                    chk("start_without_push", WIDTH'(1), WIDTH'(0));
                end else begin
                    e = iss_q.pop_front();
                    chk("issue_a", bus.gcd_a, e.a);
                    chk("issue_b", bus.gcd_b, e.b);
                end
                op_a       <= bus.gcd_a;
                op_b       <= bus.gcd_b;
                core_pend  <= 1'b1;
                core_cnt   <= core_lat;
                core_stale <= 1'b1;
                start_cyc  <= cyc + 1;
            end else if (core_stale) begin
                bus.gcd_done <= 1'b0;
                core_stale   <= 1'b0;
            end else if (core_pend && core_en) begin
                if (core_cnt == 0) begin
                    bus.gcd_done   <= 1'b1;
                    bus.gcd_result <= gcd_ref(op_a, op_b);
                    core_pend      <= 1'b0;
                end else begin
                    core_cnt <= core_cnt - 1;
                end
            end
        end
    end

    // Scoreboard monitor: each accepted result is compared once.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", WIDTH'(1), WIDTH'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("out_result", bus.out_result, e.res);
                chk("out_seq", WIDTH'(bus.out_seq), WIDTH'(e.seq));
                chk("out_err", WIDTH'(bus.out_err), WIDTH'(e.err));
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drive one pair; returns #1 after the accepting edge.
    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] res, input logic err, input bit expect_out);
        logic rdy;
        int   n;
        exp_t e;
        iss_t s;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 200) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            n++;
        end
        #1;
        bus.in_valid = 1'b0;
        if (!rdy) begin
            chk("push_timeout", WIDTH'(0), WIDTH'(1));
        end else begin
            s.a = a;
            s.b = b;
            iss_q.push_back(s);
            if (expect_out) begin
                e.res = res;
                e.seq = exp_seq;
                e.err = err;
                sb_q.push_back(e);
                exp_seq = exp_seq + 8'd1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", WIDTH'(sb_q.size()), WIDTH'(0));
    endtask

    task automatic wait_valid(input int max_cyc, output int waited);
        waited = 0;
        @(negedge clk);
        while (!bus.out_valid && waited < max_cyc) begin
            @(negedge clk);
            waited++;
        end
        chk("wait_valid", WIDTH'(bus.out_valid), WIDTH'(1));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},   WIDTH'(bus.in_ready),  WIDTH'(1));
        chk({tag, "_out_valid"},  WIDTH'(bus.out_valid), WIDTH'(0));
        chk({tag, "_out_result"}, bus.out_result,        WIDTH'(0));
        chk({tag, "_out_seq"},    WIDTH'(bus.out_seq),   WIDTH'(0));
        chk({tag, "_out_err"},    WIDTH'(bus.out_err),   WIDTH'(0));
        chk({tag, "_busy"},       WIDTH'(busy),          WIDTH'(0));
        chk({tag, "_gcd_start"},  WIDTH'(bus.gcd_start), WIDTH'(0));
        chk({tag, "_gcd_a"},      bus.gcd_a,             WIDTH'(0));
        chk({tag, "_gcd_b"},      bus.gcd_b,             WIDTH'(0));
    endtask

    initial begin
        int               w;
        logic [WIDTH-1:0] hold_res;
        logic [7:0]       hold_seq;
        int               valid_seen;

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        core_en       = 1'b1;
        core_lat      = 4;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;
        sync();

        // Single operation.
        push(48, 18, 6, 1'b0, 1'b1);
        drain();

        // Back-to-back pushes including zero operands.
        sync();
        push(7, 13, 1, 1'b0, 1'b1);
        push(0, 5, 5, 1'b0, 1'b1);
        push(0, 0, 0, 1'b0, 1'b1);
        drain();

        // Back-pressure fills the FIFO behind the stalled first result.
        sync();
        bus.out_ready = 1'b0;
        push(12, 8, 4, 1'b0, 1'b1);
        push(15, 5, 5, 1'b0, 1'b1);
        push(17, 34, 17, 1'b0, 1'b1);
        push(100, 10, 10, 1'b0, 1'b1);
        push(9, 27, 9, 1'b0, 1'b1);
        @(negedge clk);
        chk("full_in_ready", WIDTH'(bus.in_ready), WIDTH'(0));
        chk("full_busy", WIDTH'(busy), WIDTH'(1));
        repeat (10) @(negedge clk);
        chk("full_hold_in_ready", WIDTH'(bus.in_ready), WIDTH'(0));
        chk("full_out_valid", WIDTH'(bus.out_valid), WIDTH'(1));
        sync();
        bus.out_ready = 1'b1;
        push(14, 49, 7, 1'b0, 1'b1);
        drain();

        // Result held under back-pressure; next op must not start.
        sync();
        bus.out_ready = 1'b0;
        push(21, 14, 7, 1'b0, 1'b1);
        push(35, 10, 5, 1'b0, 1'b1);
        wait_valid(100, w);
        hold_res = bus.out_result;
        hold_seq = bus.out_seq;
        chk("hold_first_result", hold_res, WIDTH'(7));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_valid", WIDTH'(bus.out_valid), WIDTH'(1));
            chk("hold_result", bus.out_result, hold_res);
            chk("hold_seq", WIDTH'(bus.out_seq), WIDTH'(hold_seq));
            chk("hold_no_start", WIDTH'(bus.gcd_start), WIDTH'(0));
        end
        sync();
        bus.out_ready = 1'b1;
        drain();

        // Reset asserted while waiting on the core.
        core_lat = 30;
        sync();
        push(100, 75, 25, 1'b0, 1'b0);
        w = 0;
        while (!bus.gcd_start && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("mid_start_seen", WIDTH'(bus.gcd_start), WIDTH'(1));
        repeat (5) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        sb_q.delete();
        iss_q.delete();
        exp_seq  = 8'd0;
        core_lat = 4;
        sync();
        reset_n = 1'b1;
        sync();
        push(48, 18, 6, 1'b0, 1'b1);
        drain();

        // Core that never completes.
        core_en = 1'b0;
        sync();
`ifdef GCD_TIMEOUT_EN
        push(9, 6, 0, 1'b1, 1'b1);
        wait_valid(100, w);
        chk("timeout_latency", WIDTH'(cyc - start_cyc), WIDTH'(17));
        drain();
`else
        push(9, 6, 0, 1'b0, 1'b0);
        valid_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.out_valid) valid_seen++;
        end
        chk("no_timeout_valid", WIDTH'(valid_seen), WIDTH'(0));
        chk("no_timeout_busy", WIDTH'(busy), WIDTH'(1));
`endif
        sync();
        reset_n = 1'b0;
        sync();
        core_en = 1'b1;
        reset_n = 1'b1;
        sync();
        chk("end_issue_queue", WIDTH'(iss_q.size()), WIDTH'(0));
        chk("end_scoreboard", WIDTH'(sb_q.size()), WIDTH'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
